// File: rtl/ncl_digit_counter_pipe.sv
// ncl_digit_counter_pipe: WIDTH-digit binary counter, one NCL-style dual-rail stage per digit.
// Carries ripple one digit per clock through single-slot carry registers.
module ncl_digit_counter_pipe #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic               en,
    input  logic [WIDTH-1:0]   sumcomp,
    output logic [2*WIDTH-1:0] sum,
    output logic [WIDTH-1:0]   count,
    output logic               wrap,
    output logic               idle
);
    logic [WIDTH-1:0]   v_q, v_d, p_q, p_d;
    logic [2*WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:1]   cv_q, cv_d, cb_q, cb_d;
    logic               wrap_q, wrap_d, idle_q, idle_d;
    logic [WIDTH-1:0]   fire, ret, cin, s, co;
    logic [WIDTH:0]     cvx;

    always_comb begin
        // Digit 0 always has a valid carry-in; the top digit never sees a full slot above it.
        cvx = {1'b0, cv_q, 1'b1};
        cin = {cb_q, en};
        fire = ~p_q & ~sumcomp & cvx[WIDTH-1:0] & ~cvx[WIDTH:1];
        ret = p_q & sumcomp;
        s = v_q ^ cin;
        co = fire & v_q & cin;
        v_d = v_q ^ (fire & cin);
        p_d = (p_q | fire) & ~ret;
        cv_d = (cv_q & ~fire[WIDTH-1:1]) | fire[WIDTH-2:0];
        cb_d = (cb_q & ~fire[WIDTH-2:0]) | co[WIDTH-2:0];
        wrap_d = co[WIDTH-1];
        idle_d = ~|cv_d;
        sum_d = sum_q;
        for (int i = 0; i < WIDTH; i++)
            sum_d[2*i +: 2] = fire[i] ? {s[i], ~s[i]} : ret[i] ? 2'b00 : sum_q[2*i +: 2];
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            v_q <= INIT_VALUE;
            p_q <= '0;
            sum_q <= '0;
            cv_q <= '0;
            cb_q <= '0;
            wrap_q <= 1'b0;
            idle_q <= 1'b1;
        end else begin
            v_q <= v_d;
            p_q <= p_d;
            sum_q <= sum_d;
            cv_q <= cv_d;
            cb_q <= cb_d;
            wrap_q <= wrap_d;
            idle_q <= idle_d;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_rail_chk
        assert property (@(posedge clk) disable iff (!init_n) sum_q[2*g +: 2] != 2'b11);
    end

    assign sum = sum_q;
    assign count = v_q;
    assign wrap = wrap_q;
    assign idle = idle_q;
endmodule

// File: tb/tb_ncl_digit_counter_pipe.sv
// tb_ncl_digit_counter_pipe: directed checks on three 4-digit counters (INIT 0, 1010, 1111)
// driven by an auto-consumer that acks each non-NULL digit one cycle after it appears.
module tb_ncl_digit_counter_pipe;
    logic       clk = 1'b0;
    logic       init_n = 1'b1;
    logic       en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic [3:0] hold_a = 4'hF, hold_b = 4'hF, hold_c = 4'hF;
    logic [3:0] sc_a, sc_b, sc_c, count_a, count_b, count_c;
    logic [7:0] sum_a, sum_b, sum_c;
    logic       wrap_a, wrap_b, wrap_c, idle_a, idle_b, idle_c;
    int n_chk = 0, n_pass = 0;
    int fires_a = 0, wraps_a = 0, wraps_b = 0, wraps_c = 0, bad11 = 0, f;
    logic prev0 = 1'b0;

    always #5 clk = ~clk;

    assign sc_a = {|sum_a[7:6], |sum_a[5:4], |sum_a[3:2], |sum_a[1:0]} & ~hold_a;
    assign sc_b = {|sum_b[7:6], |sum_b[5:4], |sum_b[3:2], |sum_b[1:0]} & ~hold_b;
    assign sc_c = {|sum_c[7:6], |sum_c[5:4], |sum_c[3:2], |sum_c[1:0]} & ~hold_c;

    ncl_digit_counter_pipe #(.WIDTH(4), .INIT_VALUE(4'b0000)) u_a (
        .clk(clk), .init_n(init_n), .en(en_a), .sumcomp(sc_a),
        .sum(sum_a), .count(count_a), .wrap(wrap_a), .idle(idle_a));
    ncl_digit_counter_pipe #(.WIDTH(4), .INIT_VALUE(4'b1010)) u_b (
        .clk(clk), .init_n(init_n), .en(en_b), .sumcomp(sc_b),
        .sum(sum_b), .count(count_b), .wrap(wrap_b), .idle(idle_b));
    ncl_digit_counter_pipe #(.WIDTH(4), .INIT_VALUE(4'b1111)) u_c (
        .clk(clk), .init_n(init_n), .en(en_c), .sumcomp(sc_c),
        .sum(sum_c), .count(count_c), .wrap(wrap_c), .idle(idle_c));

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sum_a[1:0] != 2'b00 && !prev0) fires_a++;
        prev0 = sum_a[1:0] != 2'b00;
        wraps_a += int'(wrap_a);
        wraps_b += int'(wrap_b);
        wraps_c += int'(wrap_c);
        for (int i = 0; i < 4; i++)
            if (sum_a[2*i +: 2] == 2'b11 || sum_b[2*i +: 2] == 2'b11 || sum_c[2*i +: 2] == 2'b11) bad11++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        init_n = 1'b0;
        #2;
        init_n = 1'b1;
        prev0 = 1'b0;
        fires_a = 0;
        wraps_a = 0;
        wraps_b = 0;
        wraps_c = 0;
    endtask

    initial begin
        // reset state
        #1 init_n = 1'b0;
        #1;
        check("rst_sum", 32'(sum_a), 0);
        check("rst_count", 32'(count_a), 0);
        check("rst_wrap", 32'(wrap_a), 0);
        check("rst_idle", 32'(idle_a), 1);
        check("rst_count_b", 32'(count_b), 'b1010);
        check("rst_count_c", 32'(count_c), 'hF);
        // scenario 1: sumcomp held 0, first wavefront latency
        en_a = 1'b1;
        do_reset();
        tick();
        check("s1_d0", 32'(sum_a[1:0]), 'b10);
        check("s1_count", 32'(count_a), 1);
        check("s1_idle1", 32'(idle_a), 0);
        tick();
        check("s1_d1", 32'(sum_a[3:2]), 'b01);
        tick();
        tick();
        check("s1_d3", 32'(sum_a[7:6]), 'b01);
        check("s1_sum", 32'(sum_a), 'b01010110);
        check("s1_idle4", 32'(idle_a), 1);
        // scenario 2: sixteen single increments with carry ripple and one wrap
        hold_a = 4'h0;
        en_a = 1'b0;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            en_a = 1'b1;
            f = fires_a;
            for (int t = 0; t < 8 && fires_a == f; t++) tick();
            check("s2_fire", fires_a - f, 1);
            en_a = 1'b0;
            repeat (6) tick();
            check("s2_count", 32'(count_a), k % 16);
            if (k == 15) check("s2_nowrap", wraps_a, 0);
        end
        check("s2_wraps", wraps_a, 1);
        // scenario 3: digit 1 held in DATA backpressures digit 0
        en_a = 1'b1;
        do_reset();
        for (int t = 0; t < 6 && sum_a[3:2] == 2'b00; t++) tick();
        hold_a = 4'b0010;
        check("s3_d1", 32'(sum_a[3:2]), 'b01);
        f = fires_a;
        repeat (10) tick();
        check("s3_fires", fires_a - f, 1);
        check("s3_count", 32'(count_a), 0);
        check("s3_d1_held", 32'(sum_a[3:2]), 'b01);
        check("s3_d0_null", 32'(sum_a[1:0]), 0);
        check("s3_idle", 32'(idle_a), 0);
        // scenario 4: en=0 wavefronts re-present 1010
        hold_b = 4'h0;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            tick();
            check("s4_sum", 32'(sum_b), e == 1 ? 'b00000001 : e == 2 ? 'b00001000 :
                  (e % 2 == 1) ? 'b00010001 : 'b10001000);
            check("s4_count", 32'(count_b), 'b1010);
        end
        check("s4_wraps", wraps_b, 0);
        // scenario 5: 1111 + 1 ripples to 0000 with a single wrap
        hold_c = 4'h0;
        en_c = 1'b1;
        do_reset();
        tick();
        en_c = 1'b0;
        check("s5_e1", 32'(count_c), 'b1110);
        tick();
        check("s5_e2", 32'(count_c), 'b1100);
        tick();
        check("s5_e3", 32'(count_c), 'b1000);
        check("s5_wrap3", 32'(wrap_c), 0);
        tick();
        check("s5_e4", 32'(count_c), 0);
        check("s5_wrap4", 32'(wrap_c), 1);
        check("s5_d3", 32'(sum_c[7:6]), 'b01);
        tick();
        check("s5_wrap5", 32'(wrap_c), 0);
        repeat (6) tick();
        check("s5_wraps", wraps_c, 1);
        check("s5_final", 32'(count_c), 0);
        // scenario 6: asynchronous reset mid-ripple, then restart
        hold_a = 4'h0;
        en_a = 1'b1;
        do_reset();
        tick();
        tick();
        check("s6_busy", 32'(idle_a), 0);
        #2 init_n = 1'b0;
        #1;
        check("s6_sum", 32'(sum_a), 0);
        check("s6_count", 32'(count_a), 0);
        check("s6_wrap", 32'(wrap_a), 0);
        check("s6_idle", 32'(idle_a), 1);
        hold_a = 4'hF;
        @(negedge clk);
        #2 init_n = 1'b1;
        prev0 = 1'b0;
        tick();
        check("s6_d0", 32'(sum_a[1:0]), 'b10);
        check("s6_count1", 32'(count_a), 1);
        tick();
        tick();
        tick();
        check("s6_sum4", 32'(sum_a), 'b01010110);
        check("s6_idle4", 32'(idle_a), 1);
        check("no_11", bad11, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ncl_digit_counter_pipe.md
Name: ncl_digit_counter_pipe

Overview:
Clocked, parametrised successor to the four-stage dual-rail digit counter ring. It holds a WIDTH-digit binary counter. Each digit is an independent NCL-style stage that presents DATA/NULL wavefronts on a dual-rail output under a per-digit completion handshake. Carries ripple one digit per clock through single-slot carry registers, giving digit-completeness pipelining. It sits between an increment source and dual-rail consumers in the NCL sandbox clocked test harness.

Parameters:
WIDTH, 32, number of binary digits (minimum 2).
INIT_VALUE, 0, counter value loaded on reset (WIDTH bits).

Ports:
clk  input  1  clock; all state changes on the rising edge.
init_n  input  1  asynchronous, active-low reset.
en  input  1  increment request; sampled as digit-0 carry-in when digit 0 fires.
sumcomp  input  WIDTH  per-digit completion from consumer: 1 = digit DATA accepted (request NULL), 0 = NULL accepted (request DATA).
sum  output  2*WIDTH  dual-rail digits: sum[2i+1] = rail1, sum[2i] = rail0; 00 = NULL.
count  output  WIDTH  binary view of the digit values (count[i] = v[i]).
wrap  output  1  one-cycle pulse when the top digit produces carry 1.
idle  output  1  1 when no carry token is pending in slots 1..WIDTH-1.

Behaviour:
- Reset is asynchronous, active-low, and applies immediately at any time, including mid-ripple:
  - v = INIT_VALUE.
  - Every phase p[i] = 0 and sum = all NULL.
  - Carry slots cv[1..WIDTH-1] = 0; wrap = 0; idle = 1.
- Per-digit state:
  - v[i]: digit value.
  - p[i]: 0 = NULL presented, 1 = DATA presented.
  - Carry slot for i >= 1: cv[i] (valid) and cb[i] (value).
  - Digit 0 carry-in is always valid with value en.
- Digit i fires (NULL -> DATA) when all of these hold:
  - p[i] = 0;
  - sumcomp[i] = 0;
  - carry-in valid (i = 0: always; i >= 1: cv[i] = 1);
  - i = WIDTH-1, or cv[i+1] = 0.
- On fire:
  - s = v[i] xor cin, co = v[i] and cin.
  - v[i] <= s.
  - sum digit i <= s ? 10 : 01.
  - p[i] <= 1.
  - cv[i] <= 0 for i >= 1.
  - For i < WIDTH-1: cv[i+1] <= 1, cb[i+1] <= co.
  - For i = WIDTH-1: wrap <= co for exactly one cycle.
- A carry slot occupied in cycle t frees no earlier than t+1. There is no same-cycle pass-through, so no combinational ack chain exists across digits.
- Digit i returns to NULL when p[i] = 1 and sumcomp[i] = 1: sum digit i <= 00, p[i] <= 0. v is unchanged.
- Fire and return-to-NULL are mutually exclusive per digit per cycle.
- The rail state 11 is never driven; an assertion must flag it.
- Latency after reset release with sumcomp = 0:
  - Digit 0 presents DATA on the 1st edge; digit i first presents DATA on edge i+1.
  - Digit 0 minimum repeat period is 2 cycles plus consumer ack delay.
- en = 0 still cycles wavefronts: carry 0 propagates, values are unchanged, and sum re-presents the current digits.
- Wrap-around: all-ones plus 1 yields all-zeros, with wrap asserted on the cycle the top digit fires with co = 1.
- Backpressure: a digit held in DATA (sumcomp stays 0) never fires again.
  - Its slot stays full, which blocks digit i-1 after at most one further fire.
  - Stalls propagate downward only; digits above are unaffected.
- count and idle are registered with the state; count[i] changes only on a fire of digit i.

Test Plan:
1. WIDTH=4, INIT_VALUE=0, reset release, sumcomp=0, en=1 -> edge1 sum[1:0]=10, count=0001; edge2 sum[3:2]=01; edge4 sum[7:6]=01; idle=1 after edge4.
2. WIDTH=4, auto-consumer (sumcomp[i] = sum digit i non-NULL, delayed 1 cycle), en=1 for 16 digit-0 fires -> count steps 0..15 then 0; wrap pulses exactly once, when digit 3 fires with carry 1; no 11 rails.
3. WIDTH=4, auto-consumer except sumcomp[1] held 0 after digit 1 shows DATA -> digit 1 stays DATA; digit 0 fires at most once more then stays NULL; count frozen; idle=0 (slot 1 full).
4. WIDTH=4, INIT_VALUE=4'b1010, auto-consumer, en=0 for 10 digit-0 fires -> count stays 1010; each wavefront shows sum=10_01_10_01 in DATA; wrap never asserts.
5. WIDTH=4, INIT_VALUE=4'hF, auto-consumer, one en=1 fire then en=0 -> carry ripples one digit per fire; count reaches 0000; single wrap pulse on the digit-3 fire.
6. Assert init_n low asynchronously mid-ripple (cv[2]=1) -> same timestep: sum=0, count=INIT_VALUE, wrap=0, idle=1; after release the sequence restarts as in scenario 1.
